// File: rtl/commit_pkg.sv
// commit_pkg: shared entry-buffer types, unit codes and commit helpers
package commit_pkg;
  localparam int BUF_SIZE = 8;
  localparam int BUF_SIZE_LOG = 3;
  typedef logic [BUF_SIZE_LOG-1:0] index_t;
  typedef logic [5:0] tag_t;
  typedef logic [2:0] unit_t;
  localparam unit_t U_ALU = 3'd0;
  localparam unit_t U_BRANCH = 3'd1;
  localparam unit_t U_LOAD = 3'd2;
  localparam unit_t U_STORE = 3'd3;
  typedef enum logic [1:0] {S_NOT_USED, S_WAITING, S_EXECUTED} e_state_t;
  typedef enum logic [1:0] {RWMM_WORD, RWMM_HALF, RWMM_BYTE} rwmm_t;
  typedef struct packed {
    e_state_t    e_state;
    unit_t       unit;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] vk;
    rwmm_t       rwmm;
    tag_t        tag;
    logic [5:0]  speculative_tag;
    logic [5:0]  specific_speculative_tag;
  } entry_t;
  // executed and every speculative bit is either its own or released by an older retiring branch
  function automatic logic committable(entry_t e, logic [5:0] released);
    return e.e_state == S_EXECUTED && (e.speculative_tag & ~(e.specific_speculative_tag | released)) == '0;
  endfunction
endpackage

// File: rtl/commit_oldest_pair_finder.sv
// oldest_pair_finder: linear scan returning the largest and second-largest tag among unmasked live entries
module oldest_pair_finder
  import commit_pkg::*;
(
  input  entry_t             entries [BUF_SIZE],
  input  logic [BUF_SIZE-1:0] mask,
  output logic               h_valid,
  output index_t             h_index,
  output tag_t               h_tag,
  output logic               s_valid,
  output index_t             s_index,
  output tag_t               s_tag
);
  // a new maximum demotes the current head to second place
  always_comb begin
    h_valid = 1'b0;
    h_index = '0;
    h_tag = '0;
    s_valid = 1'b0;
    s_index = '0;
    s_tag = '0;
    for (int i = 0; i < BUF_SIZE; i++)
      if (entries[i].e_state != S_NOT_USED && !mask[i]) begin
        if (!h_valid || entries[i].tag > h_tag) begin
          s_valid = h_valid;
          s_index = h_index;
          s_tag = h_tag;
          h_valid = 1'b1;
          h_index = index_t'(i);
          h_tag = entries[i].tag;
        end else if (!s_valid || entries[i].tag > s_tag) begin
          s_valid = 1'b1;
          s_index = index_t'(i);
          s_tag = entries[i].tag;
        end
      end
  end
endmodule

// File: rtl/commit.sv
// commit: retires up to two oldest executed entries per cycle, performs stores via req/ack
module commit
  import commit_pkg::*;
#(
  parameter int STORE_ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  entry_t            entries_all [BUF_SIZE],
  output logic [1:0]        reg_we,
  output logic [1:0][4:0]   reg_waddr,
  output logic [1:0][31:0]  reg_wdata,
  output logic [1:0]        free_valid,
  output index_t [1:0]      free_index,
  output logic [5:0]        spectag_clear,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output rwmm_t             mem_rwmm,
  input  logic              mem_ack,
  output logic              store_retired,
  output logic              commit_error,
  output logic [31:0]       retire_count
);
  typedef enum logic {RUN, ST_WAIT} state_t;
  state_t state, state_n;
  logic [BUF_SIZE-1:0] mask, mask_n;
  index_t store_idx, store_idx_n;
  logic [15:0] timer, timer_n;
  logic [1:0] reg_we_n, free_valid_n;
  logic [1:0][4:0] reg_waddr_n;
  logic [1:0][31:0] reg_wdata_n;
  index_t [1:0] free_index_n;
  logic [5:0] spectag_clear_n, h_clear;
  logic mem_req_n, store_retired_n, commit_error_n, h_ok, s_ok;
  logic [31:0] mem_addr_n, mem_wdata_n, retire_count_n;
  rwmm_t mem_rwmm_n;
  logic h_valid, s_valid;
  index_t h_index, s_index;
  tag_t h_tag, s_tag;
  oldest_pair_finder u_finder (
    .entries(entries_all),
    .mask(mask),
    .h_valid(h_valid),
    .h_index(h_index),
    .h_tag(h_tag),
    .s_valid(s_valid),
    .s_index(s_index),
    .s_tag(s_tag)
  );
  assign h_clear = entries_all[h_index].unit == U_BRANCH ? entries_all[h_index].specific_speculative_tag : '0;
  assign h_ok = h_valid && committable(entries_all[h_index], '0);
  assign s_ok = s_valid && s_tag < h_tag && entries_all[s_index].unit != U_STORE && committable(entries_all[s_index], h_clear);
  // next-state and next-output decision; pulses default to zero, store payload defaults to held
  always_comb begin
    state_n = state;
    mask_n = '0;
    store_idx_n = store_idx;
    timer_n = timer;
    reg_we_n = '0;
    reg_waddr_n = '0;
    reg_wdata_n = '0;
    free_valid_n = '0;
    free_index_n = '0;
    spectag_clear_n = '0;
    mem_req_n = mem_req;
    mem_addr_n = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_rwmm_n = mem_rwmm;
    store_retired_n = 1'b0;
    commit_error_n = commit_error;
    if (state == RUN) begin
      if (h_ok && entries_all[h_index].unit == U_STORE) begin
        state_n = ST_WAIT;
        mem_req_n = 1'b1;
        mem_addr_n = entries_all[h_index].result;
        mem_wdata_n = entries_all[h_index].vk;
        mem_rwmm_n = entries_all[h_index].rwmm;
        store_idx_n = h_index;
        timer_n = '0;
      end else if (h_ok) begin
        reg_we_n[0] = entries_all[h_index].dest != '0;
        reg_waddr_n[0] = entries_all[h_index].dest;
        reg_wdata_n[0] = entries_all[h_index].result;
        free_valid_n[0] = 1'b1;
        free_index_n[0] = h_index;
        mask_n[h_index] = 1'b1;
        spectag_clear_n = h_clear;
        if (s_ok) begin
          reg_we_n[1] = entries_all[s_index].dest != '0;
          reg_waddr_n[1] = entries_all[s_index].dest;
          reg_wdata_n[1] = entries_all[s_index].result;
          free_valid_n[1] = 1'b1;
          free_index_n[1] = s_index;
          mask_n[s_index] = 1'b1;
          spectag_clear_n = h_clear | (entries_all[s_index].unit == U_BRANCH ? entries_all[s_index].specific_speculative_tag : '0);
        end
      end
    end else if (mem_ack) begin
      state_n = RUN;
      mem_req_n = 1'b0;
      free_valid_n[0] = 1'b1;
      free_index_n[0] = store_idx;
      mask_n[store_idx] = 1'b1;
      store_retired_n = 1'b1;
    end else begin
      timer_n = timer == 16'(STORE_ACK_TIMEOUT) ? timer : timer + 16'd1;
      commit_error_n = commit_error | (timer_n == 16'(STORE_ACK_TIMEOUT));
    end
    retire_count_n = retire_count + 32'(free_valid_n[0]) + 32'(free_valid_n[1]);
  end
  // register state and every output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      mask <= '0;
      store_idx <= '0;
      timer <= '0;
      reg_we <= '0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      free_valid <= '0;
      free_index <= '0;
      spectag_clear <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_rwmm <= RWMM_WORD;
      store_retired <= 1'b0;
      commit_error <= 1'b0;
      retire_count <= '0;
    end else begin
      state <= state_n;
      mask <= mask_n;
      store_idx <= store_idx_n;
      timer <= timer_n;
      reg_we <= reg_we_n;
      reg_waddr <= reg_waddr_n;
      reg_wdata <= reg_wdata_n;
      free_valid <= free_valid_n;
      free_index <= free_index_n;
      spectag_clear <= spectag_clear_n;
      mem_req <= mem_req_n;
      mem_addr <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_rwmm <= mem_rwmm_n;
      store_retired <= store_retired_n;
      commit_error <= commit_error_n;
      retire_count <= retire_count_n;
    end
endmodule

// File: tb/tb_commit.sv
// tb_commit: directed checks of in-order dual retire, store handshake, spec-tag gating and timeout
module tb_commit;
  import commit_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_ack = 1'b0;
  entry_t ents [BUF_SIZE];
  logic [1:0] reg_we, free_valid;
  logic [1:0][4:0] reg_waddr;
  logic [1:0][31:0] reg_wdata;
  index_t [1:0] free_index;
  logic [5:0] spectag_clear;
  logic mem_req, store_retired, commit_error;
  logic [31:0] mem_addr, mem_wdata, retire_count;
  rwmm_t mem_rwmm;
  int total = 0;
  int bad = 0;
  commit dut (
    .clk(clk), .rst_n(rst_n), .entries_all(ents),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .free_valid(free_valid), .free_index(free_index), .spectag_clear(spectag_clear),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rwmm(mem_rwmm),
    .mem_ack(mem_ack), .store_retired(store_retired), .commit_error(commit_error),
    .retire_count(retire_count)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic clear_buf();
    for (int i = 0; i < BUF_SIZE; i++) ents[i] = '0;
  endtask
  function automatic entry_t mk(e_state_t st, unit_t u, logic [4:0] d, logic [31:0] r, logic [31:0] v, tag_t t, logic [5:0] sp, logic [5:0] spc);
    entry_t e;
    e = '0;
    e.e_state = st;
    e.unit = u;
    e.dest = d;
    e.result = r;
    e.vk = v;
    e.tag = t;
    e.speculative_tag = sp;
    e.specific_speculative_tag = spc;
    return e;
  endfunction
  initial begin
    clear_buf();
    step();
    step();
    chk("rst_reg_we", 64'(reg_we), 64'd0);
    chk("rst_free", 64'(free_valid), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_count", 64'(retire_count), 64'd0);
    chk("rst_err", 64'(commit_error), 64'd0);
    rst_n = 1'b1;
    ents[2] = mk(S_EXECUTED, U_ALU, 5'd5, 32'h11, 32'h0, 6'd15, 6'd0, 6'd0);
    ents[5] = mk(S_EXECUTED, U_ALU, 5'd6, 32'h22, 32'h0, 6'd14, 6'd0, 6'd0);
    step();
    chk("pair_we", 64'(reg_we), 64'(2'b11));
    chk("pair_waddr", 64'(reg_waddr), 64'({5'd6, 5'd5}));
    chk("pair_wdata", 64'(reg_wdata), {32'h22, 32'h11});
    chk("pair_free", 64'(free_valid), 64'(2'b11));
    chk("pair_idx", 64'(free_index), 64'({3'd5, 3'd2}));
    chk("pair_count", 64'(retire_count), 64'd2);
    step();
    chk("pair_no_double", 64'(free_valid), 64'd0);
    chk("pair_we_pulse", 64'(reg_we), 64'd0);
    clear_buf();
    ents[0] = mk(S_WAITING, U_ALU, 5'd7, 32'h33, 32'h0, 6'd15, 6'd0, 6'd0);
    ents[1] = mk(S_EXECUTED, U_ALU, 5'd8, 32'h44, 32'h0, 6'd14, 6'd0, 6'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("stall_free", 64'(free_valid), 64'd0);
    end
    ents[0].e_state = S_EXECUTED;
    step();
    chk("order_free", 64'(free_valid), 64'(2'b11));
    chk("order_waddr", 64'(reg_waddr), 64'({5'd8, 5'd7}));
    chk("order_idx", 64'(free_index), 64'({3'd1, 3'd0}));
    chk("order_count", 64'(retire_count), 64'd4);
    step();
    clear_buf();
    ents[3] = mk(S_EXECUTED, U_STORE, 5'd0, 32'h100, 32'hDEAD, 6'd20, 6'd0, 6'd0);
    ents[3].rwmm = RWMM_HALF;
    ents[4] = mk(S_EXECUTED, U_ALU, 5'd9, 32'h55, 32'h0, 6'd19, 6'd0, 6'd0);
    step();
    chk("st_req", 64'(mem_req), 64'd1);
    chk("st_addr", 64'(mem_addr), 64'h100);
    chk("st_data", 64'(mem_wdata), 64'hDEAD);
    chk("st_rwmm", 64'(mem_rwmm), 64'(RWMM_HALF));
    chk("st_nofree", 64'(free_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("st_hold_req", 64'(mem_req), 64'd1);
      chk("st_hold_addr", 64'(mem_addr), 64'h100);
      chk("st_wait_free", 64'(free_valid), 64'd0);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("st_req_drop", 64'(mem_req), 64'd0);
    chk("st_free", 64'(free_valid), 64'(2'b01));
    chk("st_free_idx", 64'(free_index[0]), 64'd3);
    chk("st_retired", 64'(store_retired), 64'd1);
    chk("st_no_we", 64'(reg_we), 64'd0);
    chk("st_count", 64'(retire_count), 64'd5);
    ents[3] = '0;
    step();
    chk("st_young_we", 64'(reg_we), 64'(2'b01));
    chk("st_young_addr", 64'(reg_waddr[0]), 64'd9);
    chk("st_young_idx", 64'(free_index[0]), 64'd4);
    chk("st_retired_pulse", 64'(store_retired), 64'd0);
    chk("st_young_count", 64'(retire_count), 64'd6);
    ents[4] = '0;
    step();
    chk("st_idle", 64'(free_valid), 64'd0);
    ents[6] = mk(S_EXECUTED, U_BRANCH, 5'd0, 32'h0, 32'h0, 6'd30, 6'd0, 6'b000010);
    ents[7] = mk(S_EXECUTED, U_ALU, 5'd10, 32'h66, 32'h0, 6'd29, 6'b000010, 6'd0);
    step();
    chk("br_free", 64'(free_valid), 64'(2'b11));
    chk("br_clear", 64'(spectag_clear), 64'(6'b000010));
    chk("br_we", 64'(reg_we), 64'(2'b10));
    chk("br_count", 64'(retire_count), 64'd8);
    step();
    chk("br_clear_pulse", 64'(spectag_clear), 64'd0);
    chk("br_free_pulse", 64'(free_valid), 64'd0);
    clear_buf();
    ents[6] = mk(S_EXECUTED, U_BRANCH, 5'd0, 32'h0, 32'h0, 6'd30, 6'd0, 6'b000010);
    ents[7] = mk(S_EXECUTED, U_ALU, 5'd10, 32'h66, 32'h0, 6'd29, 6'b000110, 6'd0);
    step();
    chk("brb_free", 64'(free_valid), 64'(2'b01));
    chk("brb_clear", 64'(spectag_clear), 64'(6'b000010));
    chk("brb_count", 64'(retire_count), 64'd9);
    step();
    chk("brb_masked", 64'(free_valid), 64'd0);
    clear_buf();
    step();
    ents[1] = mk(S_EXECUTED, U_ALU, 5'd0, 32'h77, 32'h0, 6'd40, 6'd0, 6'd0);
    step();
    chk("d0_we", 64'(reg_we), 64'd0);
    chk("d0_free", 64'(free_valid), 64'(2'b01));
    chk("d0_idx", 64'(free_index[0]), 64'd1);
    chk("d0_count", 64'(retire_count), 64'd10);
    step();
    chk("d0_no_double", 64'(free_valid), 64'd0);
    chk("d0_count_hold", 64'(retire_count), 64'd10);
    clear_buf();
    step();
    ents[2] = mk(S_EXECUTED, U_STORE, 5'd0, 32'h200, 32'hBEEF, 6'd50, 6'd0, 6'd0);
    step();
    chk("to_req", 64'(mem_req), 64'd1);
    for (int k = 1; k < 255; k++) step();
    chk("to_err_before", 64'(commit_error), 64'd0);
    step();
    chk("to_err_at", 64'(commit_error), 64'd1);
    for (int k = 0; k < 45; k++) step();
    chk("to_err_sticky", 64'(commit_error), 64'd1);
    chk("to_req_held", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 64'(mem_req), 64'd0);
    chk("rst_mid_err", 64'(commit_error), 64'd0);
    chk("rst_mid_count", 64'(retire_count), 64'd0);
    chk("rst_mid_free", 64'(free_valid), 64'd0);
    clear_buf();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_req", 64'(mem_req), 64'd0);
    chk("post_rst_free", 64'(free_valid), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
